// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one buart transmit channel between
// N byte-stream requesters. Grants are held for a whole packet (until a byte
// flagged last is sent); writes are paced against the transmitter busy flag.
//
// Ports
//   clk, resetq          clock, asynchronous active-low reset
//   req_valid[N]         requester i offers a byte
//   req_data[8N]         requester i byte at [8i+7:8i]
//   req_last[N]          offered byte closes requester i's packet
//   req_ready[N]         registered one-hot accept pulse
//   tx_wr, tx_data       registered write strobe / byte to the transmitter
//   tx_busy              transmitter busy
//   owner                current or most recent grant index
//   locked               a grant is held (FSM not idle)
//
// Optional feature: define UART_ARB_TIMEOUT_EN to release a grant whose owner
// has kept req_valid low in SEND for TIMEOUT cycles.
module uart_tx_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 tx_wr,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [$clog2(N)-1:0] owner,
  output logic                 locked
);
  localparam int OW = $clog2(N);
  localparam int NP = 1 << OW;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d, ptr_q, ptr_d, pick;
  logic            tx_wr_q, tx_wr_d, last_q, last_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [N-1:0]    ready_q, ready_d;
  logic [NP-1:0]   valid_pad, last_pad, owner_hot;
  logic [8*NP-1:0] data_pad;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0]   tmo_q, tmo_d;
`endif

  // Pad requester vectors to a power of two so an owner-width index is exact.
  assign valid_pad = NP'(req_valid);
  assign last_pad  = NP'(req_last);
  assign data_pad  = (8*NP)'(req_data);
  assign owner_hot = NP'(1) << owner_q;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
    return (v == OW'(N-1)) ? '0 : v + OW'(1);
  endfunction

  // Rotating priority from ptr: scan offsets high to low so the smallest
  // offset with a valid request wins.
  always_comb begin
    logic [OW:0] cand;
    cand = '0;
    pick = ptr_q;
    for (int i = N-1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (OW+1)'(i);
      if (cand >= (OW+1)'(N)) cand = cand - (OW+1)'(N);
      if (valid_pad[cand[OW-1:0]]) pick = cand[OW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;   // strobe and accept are single-cycle pulses
    ready_d   = '0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          owner_d = pick;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (valid_pad[owner_q] && !tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = data_pad[{owner_q, 3'b000} +: 8];
          ready_d   = owner_hot[N-1:0];
          last_d    = last_pad[owner_q];
          state_d   = S_GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!valid_pad[owner_q]) begin
          // Owner went quiet: give the channel away, owner keeps old value.
          if (tmo_q == CW'(TIMEOUT-1)) begin
            ptr_d   = wrap_inc(owner_q);
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
`endif
      end
      // Transmitter latches the byte at the end of GAP; busy is valid in WAIT.
      S_GAP:  state_d = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) begin
          if (last_q) begin
            ptr_d   = wrap_inc(owner_q);
            state_d = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ready_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      ready_q   <= ready_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign tx_wr     = tx_wr_q;
  assign tx_data   = tx_data_q;
  assign owner     = owner_q;
  assign locked    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (N=4, TIMEOUT=16): cycle table, hand sequences and
// randomized packets checked against a packet-level round-robin model.
module tb_uart_tx_arb;
  localparam int N = 4;

  logic         clk = 1'b0, resetq = 1'b0;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic         tx_wr, tx_busy, locked;
  logic [7:0]   tx_data;
  logic [1:0]   owner;

  uart_tx_arb #(.N(N), .TIMEOUT(16)) dut (
    .clk(clk), .resetq(resetq), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_busy(tx_busy), .owner(owner), .locked(locked));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Direct drive (cycle table) or requester FIFOs + transmitter model.
  logic         d_mode = 1'b1, q_en = 1'b0;
  logic [N-1:0] d_valid = '0, d_last = '0;
  logic [31:0]  d_data = '0;
  logic         d_busy = 1'b0;
  logic [8:0]   mem [N][1024];
  int           wr_p [N], rd_p [N];
  logic [N-1:0] q_valid, q_last;
  logic [31:0]  q_data;
  int           bcnt = 0, frame = 4;

  always_comb begin
    q_valid = '0; q_last = '0; q_data = '0;
    for (int i = 0; i < N; i++) begin
      q_valid[i]       = q_en && (rd_p[i] != wr_p[i]);
      q_data[8*i +: 8] = mem[i][rd_p[i][9:0]][7:0];
      q_last[i]        = mem[i][rd_p[i][9:0]][8];
    end
  end
  assign req_valid = d_mode ? d_valid : q_valid;
  assign req_data  = d_mode ? d_data  : q_data;
  assign req_last  = d_mode ? d_last  : q_last;
  assign tx_busy   = d_mode ? d_busy  : (bcnt != 0);

  // Transmitter: busy for 'frame' cycles after a sampled write strobe.
  always @(posedge clk) begin
    if (tx_wr) bcnt <= frame;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [1:0] src; logic [7:0] data; logic last; } ent_t;
  ent_t log_q[$], exp_q[$];
  logic prev_busy = 1'b0, pace_chk = 1'b0, pace_seen = 1'b0, prev_last = 1'b0;
  int   fall_cyc = 0;

  // Monitor: logs every write, checks strobe rules, pops the accepted byte.
  always @(negedge clk) begin
    int s;
    logic lst;
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
    if (!pace_chk) pace_seen = 1'b0;
    if (tx_wr) begin
      s = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) s = i;
      lst = mem[s][rd_p[s][9:0]][8];
      check("wr_while_busy", 32'(tx_busy), 32'd0);
      check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      check("owner_at_wr", 32'(owner), 32'(s));
      if (pace_chk && pace_seen)
        check("pace", 32'(cyc - fall_cyc), prev_last ? 32'd3 : 32'd2);
      pace_seen = pace_chk;
      prev_last = lst;
      log_q.push_back('{src: 2'(s), data: tx_data, last: lst});
    end
    if (!d_mode)
      for (int i = 0; i < N; i++) if (req_ready[i]) rd_p[i] = rd_p[i] + 1;
  end

  task automatic push_byte(input int i, input logic [7:0] b, input logic l);
    mem[i][wr_p[i][9:0]] = {l, b};
    wr_p[i]++;
  endtask

  task automatic expect_ent(input int s, input logic [7:0] b);
    exp_q.push_back('{src: 2'(s), data: b, last: 1'b0});
  endtask

  task automatic wait_writes(input int target, input int budget, input string nm);
    int t = 0;
    while (log_q.size() < target && t < budget) begin @(negedge clk); t++; end
    check(nm, 32'(log_q.size() >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (locked && t < budget) begin @(negedge clk); t++; end
    check("unlock", 32'(locked), 32'd0);
  endtask

  task automatic compare_exp(input int base, input string nm);
    for (int j = 0; j < exp_q.size(); j++) begin
      if (base + j < log_q.size()) begin
        check({nm, "_src"},  32'(log_q[base+j].src),  32'(exp_q[j].src));
        check({nm, "_data"}, 32'(log_q[base+j].data), 32'(exp_q[j].data));
      end
    end
    exp_q.delete();
  endtask

  int mptr = 0;
  task automatic do_reset();
    @(negedge clk);
    resetq = 1'b0;
    for (int i = 0; i < N; i++) wr_p[i] = rd_p[i];
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    mptr = 0;
  endtask

  // Packet-level model: serve whole packets, rotating from the slot after
  // the previous winner, until all requester FIFOs are drained.
  task automatic model_run();
    int mp [N];
    int sel;
    logic [8:0] e;
    for (int i = 0; i < N; i++) mp[i] = rd_p[i];
    forever begin
      sel = -1;
      for (int k = N-1; k >= 0; k--)
        if (mp[(mptr+k)%N] != wr_p[(mptr+k)%N]) sel = (mptr+k)%N;
      if (sel < 0) break;
      do begin
        e = mem[sel][mp[sel][9:0]];
        expect_ent(sel, e[7:0]);
        mp[sel]++;
      end while (!e[8]);
      mptr = (sel + 1) % N;
    end
  endtask

  typedef struct {
    logic [3:0] v; logic [31:0] d; logic [3:0] l; logic b; logic [15:0] e;
  } vec_t;
  vec_t vec[21];
  function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic b,
                              logic wr, logic [3:0] rdy, logic [1:0] own, logic lk,
                              logic [7:0] txd);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.b = b; r.e = {wr, rdy, own, lk, txd};
    return r;
  endfunction

  initial begin
    int base, tot;
    for (int i = 0; i < N; i++) begin
      wr_p[i] = 0; rd_p[i] = 0;
      for (int j = 0; j < 1024; j++) mem[i][j] = '0;
    end
    // inputs per cycle -> outputs after that cycle's edge {wr,rdy,own,lk,txd}
    vec[0]  = mk(4'h0, 32'h0,    4'h0, 0, 0, 4'h0, 0, 0, 8'h00);
    vec[1]  = mk(4'h1, 32'h55,   4'h1, 0, 0, 4'h0, 0, 1, 8'h00);
    vec[2]  = mk(4'h1, 32'h55,   4'h1, 0, 1, 4'h1, 0, 1, 8'h55);
    vec[3]  = mk(4'h0, 32'h0,    4'h0, 0, 0, 4'h0, 0, 1, 8'h55);
    vec[4]  = mk(4'h0, 32'h0,    4'h0, 1, 0, 4'h0, 0, 1, 8'h55);
    vec[5]  = mk(4'h0, 32'h0,    4'h0, 1, 0, 4'h0, 0, 1, 8'h55);
    vec[6]  = mk(4'h0, 32'h0,    4'h0, 0, 0, 4'h0, 0, 0, 8'h55);
    vec[7]  = mk(4'h3, 32'h2110, 4'h0, 0, 0, 4'h0, 1, 1, 8'h55);
    vec[8]  = mk(4'h3, 32'h2110, 4'h0, 0, 1, 4'h2, 1, 1, 8'h21);
    vec[9]  = mk(4'h3, 32'h2210, 4'h2, 0, 0, 4'h0, 1, 1, 8'h21);
    vec[10] = mk(4'h3, 32'h2210, 4'h2, 1, 0, 4'h0, 1, 1, 8'h21);
    vec[11] = mk(4'h3, 32'h2210, 4'h2, 0, 0, 4'h0, 1, 1, 8'h21);
    vec[12] = mk(4'h3, 32'h2210, 4'h2, 0, 1, 4'h2, 1, 1, 8'h22);
    vec[13] = mk(4'h1, 32'h10,   4'h0, 0, 0, 4'h0, 1, 1, 8'h22);
    vec[14] = mk(4'h1, 32'h10,   4'h0, 0, 0, 4'h0, 1, 0, 8'h22);
    vec[15] = mk(4'h1, 32'h10,   4'h0, 0, 0, 4'h0, 0, 1, 8'h22);
    vec[16] = mk(4'h1, 32'h10,   4'h0, 1, 0, 4'h0, 0, 1, 8'h22);
    vec[17] = mk(4'h1, 32'h10,   4'h0, 0, 1, 4'h1, 0, 1, 8'h10);
    vec[18] = mk(4'h0, 32'h0,    4'h0, 0, 0, 4'h0, 0, 1, 8'h10);
    vec[19] = mk(4'h0, 32'h0,    4'h0, 0, 0, 4'h0, 0, 1, 8'h10);
    vec[20] = mk(4'h0, 32'h0,    4'h0, 0, 0, 4'h0, 0, 1, 8'h10);

    repeat (3) @(negedge clk);
    check("reset_state", 32'({tx_wr, req_ready, owner, locked, tx_data}), 32'd0);
    resetq = 1'b1;
    for (int r = 0; r < 21; r++) begin
      d_valid = vec[r].v; d_data = vec[r].d; d_last = vec[r].l; d_busy = vec[r].b;
      @(negedge clk);
      check($sformatf("vec%0d", r), 32'({tx_wr, req_ready, owner, locked, tx_data}),
            32'(vec[r].e));
    end

    // Round robin: every requester holds two single-byte packets.
    d_mode = 1'b0; q_en = 1'b1; frame = 3;
    do_reset();
    base = log_q.size();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        push_byte(i, 8'(16*i + p), 1'b1);
        expect_ent(i, 8'(16*i + p));
      end
    wait_writes(base + 8, 600, "rr_done");
    compare_exp(base, "rr");
    wait_idle(50);

    // Packet lock: req1's 3-byte packet is not interrupted by req2.
    base = log_q.size();
    push_byte(1, 8'hA1, 1'b0); push_byte(1, 8'hA2, 1'b0); push_byte(1, 8'hA3, 1'b1);
    push_byte(2, 8'hB2, 1'b1);
    expect_ent(1, 8'hA1); expect_ent(1, 8'hA2); expect_ent(1, 8'hA3); expect_ent(2, 8'hB2);
    wait_writes(base + 4, 400, "lock_done");
    compare_exp(base, "lock");
    wait_idle(50);

    // Randomized packets against the model, with pacing checks.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      q_en = 1'b0; pace_chk = 1'b0;
      @(negedge clk);
      frame = $urandom_range(1, 10);
      tot = 0;
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
          tot += len;
        end
      end
      if (tot == 0) begin push_byte(t % N, 8'($urandom), 1'b1); tot = 1; end
      base = log_q.size();
      model_run();
      pace_chk = 1'b1; q_en = 1'b1;
      wait_writes(base + tot, tot * 20 + 50, "rand_done");
      compare_exp(base, "rand");
      pace_chk = 1'b0;
      wait_idle(50);
    end

    // Reset while in WAIT of req2's packet; afterwards ptr restarts at 0.
    do_reset();
    frame = 6;
    base = log_q.size();
    push_byte(1, 8'h11, 1'b1);
    wait_writes(base + 1, 50, "pre_rst_w1");
    wait_idle(50);
    push_byte(2, 8'h21, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h23, 1'b1);
    wait_writes(base + 2, 50, "pre_rst_w2");
    repeat (2) @(negedge clk);
    check("pre_rst_owner", 32'({owner, locked}), 32'({2'd2, 1'b1}));
    #2 resetq = 1'b0;
    #1 check("async_rst", 32'({tx_wr, req_ready, owner, locked}), 32'd0);
    for (int i = 0; i < N; i++) wr_p[i] = rd_p[i];
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    base = log_q.size();
    push_byte(0, 8'h0A, 1'b1); push_byte(2, 8'h2A, 1'b1);
    expect_ent(0, 8'h0A); expect_ent(2, 8'h2A);
    wait_writes(base + 2, 100, "post_rst_done");
    compare_exp(base, "post_rst");
    wait_idle(50);

    // Owner stalls mid-packet while req3 waits.
    do_reset();
    frame = 4;
    base = log_q.size();
    push_byte(0, 8'hC0, 1'b0); push_byte(3, 8'hD3, 1'b1);
    expect_ent(0, 8'hC0);
    wait_writes(base + 1, 50, "tmo_first");
    compare_exp(base, "tmo_first");
`ifdef UART_ARB_TIMEOUT_EN
    expect_ent(3, 8'hD3);
    wait_writes(base + 2, 80, "tmo_release");
    compare_exp(base + 1, "tmo_release");
`else
    repeat (80) @(negedge clk);
    check("no_release_writes", 32'(log_q.size()), 32'(base + 1));
    check("no_release_grant", 32'({owner, locked}), 32'({2'd0, 1'b1}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
